// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, DATA_BITS data LSB-first, optional parity, STOP_BITS stop bits.
// Optional parity bit and parity_odd port are enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic [31:0]          divisor,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    state_t               state, state_n;
    logic [31:0]          cnt, cnt_n;
    logic [31:0]          div_q, div_n;
    logic [3:0]           bit_idx, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 tx_n;
    logic                 done_n;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_n;
`endif

    assign bit_end = (cnt == div_q);

    always_comb begin
        state_n = state;
        cnt_n   = bit_end ? '0 : cnt + 32'd1;
        div_n   = div_q;
        bit_n   = bit_idx;
        shift_n = shift;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (tx_valid) begin
                    shift_n = tx_data;
                    div_n   = divisor;
                    state_n = S_START;
`ifdef UART_TX_PARITY_EN
                    par_n   = parity_odd;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
`ifdef UART_TX_PARITY_EN
                    // parity folded in bit by bit since the shift register is consumed
                    par_n   = par_q ^ shift[0];
`endif
                    if (bit_idx == LAST_DATA) begin
                        bit_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n = bit_idx + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    bit_n   = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_idx == LAST_STOP) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        bit_n = bit_idx + 4'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // line level follows the next state so tx is a clean register output
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_n = par_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            div_q    <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            div_q    <= div_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            tx       <= tx_n;
            tx_ready <= (state_n == S_IDLE);
            busy     <= (state_n != S_IDLE);
            tx_done  <= done_n;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_n;
`endif
        end
    end

endmodule
